imem_encoder: RTL

Sequential instruction encoder and loader. It accepts decoded instruction fields (format, opcode, registers, funct3/funct7, immediate) over a valid/ready stream and packs them into 32-bit RV32I instruction words. It writes those words into consecutive instruction-memory locations. It is the write-side counterpart of the main decoder: it produces the opcode and immediate layouts that the decoder and sign-extend block consume, and it fills instruction memory before the core is released from reset.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/instr_pack.sv | 52 +++++
 rtl/imem_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, major opcodes, canonical nop.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_I_AL   = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] s;
    s = $unsigned($signed(v) >>> (n - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer with immediate range/format error flag.
// Zero latency; no flow control.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  always_comb begin
    word_o = NOP_WORD;
    err_o  = 1'b0;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
        err_o  = !fits_signed(imm_i, 12);
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
        err_o  = !fits_signed(imm_i, 12);
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], op_i};
        err_o  = !fits_signed(imm_i, 13) || imm_i[0];
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, op_i};
        err_o  = |imm_i[11:0];
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
        err_o  = !fits_signed(imm_i, 21) || imm_i[0];
      end
      // Illegal formats still produce a harmless word so memory stays well-formed.
      default: begin
        word_o = NOP_WORD;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_encoder.sv
// Session loader: packs field bundles into RV32I words and writes them to consecutive imem addresses.
// One-cycle accept-to-write latency; in_ready only in LOAD until the last bundle is taken.
module imem_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-2:0] ONE  = (ADDR_WIDTH-1)'(1);

  state_t                state_q;
  logic                  in_ready_q, mem_we_q, done_q, err_q, last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-2:0] count_q;

  logic        accept;
  logic [31:0] pack_word;
  logic        pack_err;

  assign accept = in_valid && in_ready_q;

  instr_pack u_pack (
    .fmt_i    (in_fmt),
    .op_i     (in_op),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      mem_we_q <= accept;
      // mem_addr shows the address of the word being written; it advances once that write retires.
      if (mem_we_q) begin
        addr_q  <= addr_q + STEP;
        count_q <= count_q + ONE;
      end
      if (accept) begin
        wdata_q <= pack_word;
        err_q   <= err_q | pack_err;
        if (in_last) begin
          in_ready_q <= 1'b0;
          last_q     <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
            addr_q     <= BASE;
            count_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (mem_we_q && last_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule
